// File: rtl/enemies_controller.sv
// enemies_controller
//   Owns the 8-slot enemy table. Enemies are spawned from a free-running LFSR
//   and advance toward the player on frame ticks. Player shots are resolved
//   against the nearest enemy on the fired angle, and each hit flashes that
//   angle on the angles_hit bus for a few frames.
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   frame_tick           one-cycle pulse per video frame
//   game_enable          1 = spawn/move/fire active, 0 = table frozen
//   game_start           one-cycle synchronous clear of table/score/flashes
//   fire_valid/angle     shot request; accepted when fire_valid & fire_ready
//   fire_ready           high only when the shot engine is idle and enabled
//   state[151:0]         slot i = {alive,angle[3:0],kind[1:0],distance[7:0],health[3:0]}
//   angles_hit[15:0]     bit a set while angle a is flashing
//   kill, player_hit     one-cycle event pulses
//   score[15:0]          saturating kill count
module enemies_controller #(
    parameter int          SPAWN_INTERVAL = 60,
    parameter int          MOVE_DIV       = 2,
    parameter logic [7:0]  SPAWN_DISTANCE = 8'd200,
    parameter logic [2:0]  HIT_FLASH      = 3'd6,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         game_enable,
    input  logic         game_start,
    input  logic         fire_valid,
    input  logic [3:0]   fire_angle,
    output logic         fire_ready,
    output logic [151:0] state,
    output logic [15:0]  angles_hit,
    output logic         kill,
    output logic         player_hit,
    output logic [15:0]  score
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_APPLY = 2'd2
    } shot_state_e;

    logic [7:0]  alive_q, alive_d;
    logic [3:0]  angle_q [8];
    logic [3:0]  angle_d [8];
    logic [1:0]  kind_q  [8];
    logic [1:0]  kind_d  [8];
    logic [7:0]  dist_q  [8];
    logic [7:0]  dist_d  [8];
    logic [3:0]  hp_q    [8];
    logic [3:0]  hp_d    [8];
    logic [2:0]  flash_q [16];
    logic [2:0]  flash_d [16];
    logic [15:0] score_q, score_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] spawn_cnt_q, spawn_cnt_d;
    logic [15:0] move_cnt_q, move_cnt_d;
    shot_state_e fsm_q, fsm_d;
    logic [3:0]  shot_angle_q, shot_angle_d;
    logic [2:0]  scan_idx_q, scan_idx_d;
    logic        best_valid_q, best_valid_d;
    logic [2:0]  best_idx_q, best_idx_d;
    logic [7:0]  best_dist_q, best_dist_d;
    logic        kill_q, kill_d;
    logic        phit_q, phit_d;

    logic        spawn_go_s, move_go_s, free_found_s;
    logic [2:0]  free_idx_s;
    logic [7:0]  step_s;

    assign fire_ready = (fsm_q == S_IDLE) & game_enable;
    assign kill       = kill_q;
    assign player_hit = phit_q;
    assign score      = score_q;

    for (genvar g = 0; g < 8; g++) begin : g_state
        assign state[19*g +: 19] = {alive_q[g], angle_q[g], kind_q[g], dist_q[g], hp_q[g]};
    end
    for (genvar a = 0; a < 16; a++) begin : g_hit
        assign angles_hit[a] = (flash_q[a] != 3'd0);
    end

    // Next-state logic for the table, counters, flashes and shot engine.
    always_comb begin
        alive_d      = alive_q;
        angle_d      = angle_q;
        kind_d       = kind_q;
        dist_d       = dist_q;
        hp_d         = hp_q;
        flash_d      = flash_q;
        score_d      = score_q;
        spawn_cnt_d  = spawn_cnt_q;
        move_cnt_d   = move_cnt_q;
        fsm_d        = fsm_q;
        shot_angle_d = shot_angle_q;
        scan_idx_d   = scan_idx_q;
        best_valid_d = best_valid_q;
        best_idx_d   = best_idx_q;
        best_dist_d  = best_dist_q;
        kill_d       = 1'b0;
        phit_d       = 1'b0;
        spawn_go_s   = 1'b0;
        move_go_s    = 1'b0;
        free_found_s = 1'b0;
        free_idx_s   = 3'd0;
        step_s       = 8'd1;
        // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0; free-running.
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        if (game_start) begin
            alive_d      = 8'd0;
            score_d      = 16'd0;
            spawn_cnt_d  = 16'd0;
            move_cnt_d   = 16'd0;
            fsm_d        = S_IDLE;
            scan_idx_d   = 3'd0;
            best_valid_d = 1'b0;
            for (int i = 0; i < 8; i++) begin
                angle_d[i] = 4'd0;
                kind_d[i]  = 2'd0;
                dist_d[i]  = 8'd0;
                hp_d[i]    = 4'd0;
            end
            for (int a = 0; a < 16; a++) begin
                flash_d[a] = 3'd0;
            end
        end else begin
            if (frame_tick && game_enable) begin
                if (spawn_cnt_q == 16'(SPAWN_INTERVAL - 1)) begin
                    spawn_cnt_d = 16'd0;
                    spawn_go_s  = 1'b1;
                end else begin
                    spawn_cnt_d = spawn_cnt_q + 16'd1;
                end
                if (move_cnt_q == 16'(MOVE_DIV - 1)) begin
                    move_cnt_d = 16'd0;
                    move_go_s  = 1'b1;
                end else begin
                    move_cnt_d = move_cnt_q + 16'd1;
                end
            end else begin
                spawn_go_s = 1'b0;
            end

            for (int a = 0; a < 16; a++) begin
                if (frame_tick && flash_q[a] != 3'd0) begin
                    flash_d[a] = flash_q[a] - 3'd1;
                end else begin
                    flash_d[a] = flash_q[a];
                end
            end

            case (fsm_q)
                S_IDLE: begin
                    if (fire_valid && game_enable) begin
                        shot_angle_d = fire_angle;
                        best_valid_d = 1'b0;
                        scan_idx_d   = 3'd0;
                        fsm_d        = S_SCAN;
                    end else begin
                        fsm_d = S_IDLE;
                    end
                end
                S_SCAN: begin
                    // Strict '<' keeps the lower index on equal distances.
                    if (alive_q[scan_idx_q] && angle_q[scan_idx_q] == shot_angle_q &&
                        (!best_valid_q || dist_q[scan_idx_q] < best_dist_q)) begin
                        best_valid_d = 1'b1;
                        best_idx_d   = scan_idx_q;
                        best_dist_d  = dist_q[scan_idx_q];
                    end else begin
                        best_valid_d = best_valid_q;
                    end
                    scan_idx_d = scan_idx_q + 3'd1;
                    if (scan_idx_q == 3'd7) begin
                        fsm_d = S_APPLY;
                    end else begin
                        fsm_d = S_SCAN;
                    end
                end
                S_APPLY: begin
                    fsm_d = S_IDLE;
                    // Re-check the slot: it may have died or been respawned during the scan.
                    if (best_valid_q && alive_q[best_idx_q] && angle_q[best_idx_q] == shot_angle_q) begin
                        hp_d[best_idx_q]      = hp_q[best_idx_q] - 4'd1;
                        flash_d[shot_angle_q] = HIT_FLASH;
                        if (hp_q[best_idx_q] == 4'd1) begin
                            alive_d[best_idx_q] = 1'b0;
                            kill_d              = 1'b1;
                            if (score_q != 16'hFFFF) begin
                                score_d = score_q + 16'd1;
                            end else begin
                                score_d = score_q;
                            end
                        end else begin
                            kill_d = 1'b0;
                        end
                    end else begin
                        kill_d = 1'b0;
                    end
                end
                default: fsm_d = S_IDLE;
            endcase

            // Movement sees the post-hit slot, so a killed slot is not also moved.
            if (move_go_s) begin
                for (int i = 0; i < 8; i++) begin
                    step_s = (kind_d[i] == 2'd2) ? 8'd2 : 8'd1;
                    if (alive_d[i]) begin
                        if (dist_d[i] <= step_s) begin
                            alive_d[i] = 1'b0;
                            dist_d[i]  = 8'd0;
                            phit_d     = 1'b1;
                        end else begin
                            dist_d[i] = dist_d[i] - step_s;
                        end
                    end else begin
                        dist_d[i] = dist_d[i];
                    end
                end
            end else begin
                step_s = 8'd1;
            end

            // Free slot is chosen from the registered table, so slots freed this cycle wait.
            if (spawn_go_s) begin
                for (int i = 7; i >= 0; i--) begin
                    if (!alive_q[i]) begin
                        free_found_s = 1'b1;
                        free_idx_s   = 3'(i);
                    end else begin
                        free_found_s = free_found_s;
                    end
                end
                if (free_found_s) begin
                    alive_d[free_idx_s] = 1'b1;
                    angle_d[free_idx_s] = lfsr_q[3:0];
                    kind_d[free_idx_s]  = lfsr_q[5:4];
                    dist_d[free_idx_s]  = SPAWN_DISTANCE;
                    hp_d[free_idx_s]    = 4'd1 << lfsr_q[5:4];
                end else begin
                    alive_d = alive_d;
                end
            end else begin
                free_found_s = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive_q      <= 8'd0;
            score_q      <= 16'd0;
            lfsr_q       <= LFSR_SEED;
            spawn_cnt_q  <= 16'd0;
            move_cnt_q   <= 16'd0;
            fsm_q        <= S_IDLE;
            shot_angle_q <= 4'd0;
            scan_idx_q   <= 3'd0;
            best_valid_q <= 1'b0;
            best_idx_q   <= 3'd0;
            best_dist_q  <= 8'd0;
            kill_q       <= 1'b0;
            phit_q       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                angle_q[i] <= 4'd0;
                kind_q[i]  <= 2'd0;
                dist_q[i]  <= 8'd0;
                hp_q[i]    <= 4'd0;
            end
            for (int a = 0; a < 16; a++) begin
                flash_q[a] <= 3'd0;
            end
        end else begin
            alive_q      <= alive_d;
            angle_q      <= angle_d;
            kind_q       <= kind_d;
            dist_q       <= dist_d;
            hp_q         <= hp_d;
            flash_q      <= flash_d;
            score_q      <= score_d;
            lfsr_q       <= lfsr_d;
            spawn_cnt_q  <= spawn_cnt_d;
            move_cnt_q   <= move_cnt_d;
            fsm_q        <= fsm_d;
            shot_angle_q <= shot_angle_d;
            scan_idx_q   <= scan_idx_d;
            best_valid_q <= best_valid_d;
            best_idx_q   <= best_idx_d;
            best_dist_q  <= best_dist_d;
            kill_q       <= kill_d;
            phit_q       <= phit_d;
        end
    end

endmodule
